// File: rtl/time_set_if.sv
// rtl/time_set_if.sv - button, running-time and preset signals of the time-set controller
interface time_set_if;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic [3:0] cur_sec1;
    logic [2:0] cur_sec10;
    logic [3:0] cur_min1;
    logic [2:0] cur_min10;
    logic [3:0] cur_hr1;
    logic [1:0] cur_hr10;
    logic       set_active;
    logic [1:0] sel;
    logic       blink;
    logic       load;
    logic [3:0] ld_sec1;
    logic [2:0] ld_sec10;
    logic [3:0] ld_min1;
    logic [2:0] ld_min10;
    logic [3:0] ld_hr1;
    logic [1:0] ld_hr10;

    modport master (
        output btn_mode, btn_up, btn_down,
        output cur_sec1, cur_sec10, cur_min1, cur_min10, cur_hr1, cur_hr10,
        input  set_active, sel, blink, load,
        input  ld_sec1, ld_sec10, ld_min1, ld_min10, ld_hr1, ld_hr10
    );

    modport slave (
        input  btn_mode, btn_up, btn_down,
        input  cur_sec1, cur_sec10, cur_min1, cur_min10, cur_hr1, cur_hr10,
        output set_active, sel, blink, load,
        output ld_sec1, ld_sec10, ld_min1, ld_min10, ld_hr1, ld_hr10
    );
endinterface

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - debounced buttons, field-select FSM and BCD shadow time editor
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1250000,
    parameter int BLINK_CYCLES    = 62500000
) (
    input  logic         CLK,
    input  logic         RESET,
    time_set_if.slave    bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } state_t;

    // Button index: 0 = mode, 1 = up, 2 = down
    logic [2:0]    raw;
    logic [2:0]    s1_q, s2_q, db_q, db_d, press_q;
    logic [DW-1:0] cnt_q [3];
    logic [DW-1:0] cnt_d [3];

    assign raw = {bus.btn_down, bus.btn_up, bus.btn_mode};

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DEB_MAX) begin
                    db_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_q    <= '0;
            s2_q    <= '0;
            db_q    <= '0;
            press_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            db_q    <= db_d;
            press_q <= db_d & ~db_q;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    logic press_mode, press_up, press_down;
    assign press_mode = press_q[0];
    assign press_up   = press_q[1];
    assign press_down = press_q[2];

    function automatic logic [5:0] step_hr(input logic [1:0] t, input logic [3:0] o,
                                           input logic up);
        logic [1:0] nt;
        logic [3:0] no;
        nt = t;
        no = o;
        if (up) begin
            if (t == 2'd2 && o == 4'd3) begin
                nt = 2'd0; no = 4'd0;
            end else if (o >= 4'd9) begin
                nt = t + 2'd1; no = 4'd0;
            end else begin
                no = o + 4'd1;
            end
        end else begin
            if (t == 2'd0 && o == 4'd0) begin
                nt = 2'd2; no = 4'd3;
            end else if (o == 4'd0) begin
                nt = t - 2'd1; no = 4'd9;
            end else begin
                no = o - 4'd1;
            end
        end
        return {nt, no};
    endfunction

    function automatic logic [6:0] step_60(input logic [2:0] t, input logic [3:0] o,
                                           input logic up);
        logic [2:0] nt;
        logic [3:0] no;
        nt = t;
        no = o;
        if (up) begin
            if (t >= 3'd5 && o >= 4'd9) begin
                nt = 3'd0; no = 4'd0;
            end else if (o >= 4'd9) begin
                nt = t + 3'd1; no = 4'd0;
            end else begin
                no = o + 4'd1;
            end
        end else begin
            if (t == 3'd0 && o == 4'd0) begin
                nt = 3'd5; no = 4'd9;
            end else if (o == 4'd0) begin
                nt = t - 3'd1; no = 4'd9;
            end else begin
                no = o - 4'd1;
            end
        end
        return {nt, no};
    endfunction

    state_t        state_q, state_d;
    logic          load_q, load_d;
    logic [1:0]    sel_q;
    logic          act_q;
    logic          blink_q, blink_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [1:0]    hr10_q, hr10_d;
    logic [3:0]    hr1_q, hr1_d, min1_q, min1_d, sec1_q, sec1_d;
    logic [2:0]    min10_q, min10_d, sec10_q, sec10_d;
    logic          edit;

    // Mode wins over any edit in the same cycle; up+down together cancel out.
    assign edit = !press_mode && (press_up ^ press_down);

    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        hr10_d  = hr10_q;
        hr1_d   = hr1_q;
        min10_d = min10_q;
        min1_d  = min1_q;
        sec10_d = sec10_q;
        sec1_d  = sec1_q;
        case (state_q)
            RUN: begin
                if (press_mode) begin
                    state_d = SET_HR;
                    hr10_d  = bus.cur_hr10;
                    hr1_d   = bus.cur_hr1;
                    min10_d = bus.cur_min10;
                    min1_d  = bus.cur_min1;
                    sec10_d = bus.cur_sec10;
                    sec1_d  = bus.cur_sec1;
                end
            end
            SET_HR: begin
                if (press_mode) state_d = SET_MIN;
                else if (edit) {hr10_d, hr1_d} = step_hr(hr10_q, hr1_q, press_up);
            end
            SET_MIN: begin
                if (press_mode) state_d = SET_SEC;
                else if (edit) {min10_d, min1_d} = step_60(min10_q, min1_q, press_up);
            end
            SET_SEC: begin
                if (press_mode) begin
                    state_d = RUN;
                    load_d  = 1'b1;
                end else if (edit) begin
                    {sec10_d, sec1_d} = step_60(sec10_q, sec1_q, press_up);
                end
            end
            default: state_d = RUN;
        endcase

        blink_d = blink_q;
        bcnt_d  = bcnt_q;
        if (state_d != state_q || state_q == RUN) begin
            blink_d = 1'b0;
            bcnt_d  = '0;
        end else if (bcnt_q == BLINK_MAX) begin
            blink_d = ~blink_q;
            bcnt_d  = '0;
        end else begin
            bcnt_d = bcnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= RUN;
            load_q  <= 1'b0;
            sel_q   <= 2'd0;
            act_q   <= 1'b0;
            blink_q <= 1'b0;
            bcnt_q  <= '0;
            hr10_q  <= '0;
            hr1_q   <= '0;
            min10_q <= '0;
            min1_q  <= '0;
            sec10_q <= '0;
            sec1_q  <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            sel_q   <= state_d;
            act_q   <= (state_d != RUN);
            blink_q <= blink_d;
            bcnt_q  <= bcnt_d;
            hr10_q  <= hr10_d;
            hr1_q   <= hr1_d;
            min10_q <= min10_d;
            min1_q  <= min1_d;
            sec10_q <= sec10_d;
            sec1_q  <= sec1_d;
        end
    end

    assign bus.set_active = act_q;
    assign bus.sel        = sel_q;
    assign bus.blink      = blink_q;
    assign bus.load       = load_q;
    assign bus.ld_hr10    = hr10_q;
    assign bus.ld_hr1     = hr1_q;
    assign bus.ld_min10   = min10_q;
    assign bus.ld_min1    = min1_q;
    assign bus.ld_sec10   = sec10_q;
    assign bus.ld_sec1    = sec1_q;
endmodule
